// File: rtl/seq_match_tracker.sv
// seq_match_tracker: hardware tracker for "a_clk ##1 matched ##1 d_clk" with overlapping
// attempts and saturating match/failure statistics. Define SEQ_TRK_FAIL_CNT_EN to build fail_cnt.
module seq_match_tracker #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             a_clk,
  input  logic             ev_pulse,
  input  logic             d_clk,
  output logic             match_o,
  output logic             pending_o,
  output logic             ovf_o,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  // Adds 0..3 to a counter and clamps at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, base} + {{(CNT_W-1){1'b0}}, inc};
    if (sum[CNT_W]) begin
      sat_add = {CNT_W{1'b1}};
    end else begin
      sat_add = sum[CNT_W-1:0];
    end
  endfunction

  logic             att1_q, att1_d;
  logic             att2_q, att2_d;
  logic             pending_q, pending_d;
  logic             match_q, match_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic             m_s;
  logic             hit_s;

  // A same-cycle end-point counts as matched, so the pulse bypasses the latch.
  assign m_s   = pending_q | ev_pulse;
  assign hit_s = att2_q & d_clk;

  // Next-state for the attempt pipeline, pending latch, overflow and match counter.
  always_comb begin
    att1_d      = 1'b0;
    att2_d      = 1'b0;
    pending_d   = 1'b0;
    match_d     = 1'b0;
    ovf_d       = 1'b0;
    match_cnt_d = {CNT_W{1'b0}};
    if (clr) begin
      att1_d      = 1'b0;
      att2_d      = 1'b0;
      pending_d   = 1'b0;
      match_d     = 1'b0;
      ovf_d       = 1'b0;
      match_cnt_d = {CNT_W{1'b0}};
    end else begin
      att1_d    = a_clk;
      att2_d    = att1_q & m_s;
      match_d   = hit_s;
      // The first stage-1 evaluation consumes the latched end-point.
      pending_d = m_s & ~att1_q;
      ovf_d     = ovf_q | (ev_pulse & pending_q & ~att1_q);
      if (hit_s) begin
        match_cnt_d = sat_add(match_cnt_q, 2'd1);
      end else begin
        match_cnt_d = match_cnt_q;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      att1_q      <= 1'b0;
      att2_q      <= 1'b0;
      pending_q   <= 1'b0;
      match_q     <= 1'b0;
      ovf_q       <= 1'b0;
      match_cnt_q <= {CNT_W{1'b0}};
    end else begin
      att1_q      <= att1_d;
      att2_q      <= att2_d;
      pending_q   <= pending_d;
      match_q     <= match_d;
      ovf_q       <= ovf_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  assign match_o   = match_q;
  assign pending_o = pending_q;
  assign ovf_o     = ovf_q;
  assign match_cnt = match_cnt_q;

`ifdef SEQ_TRK_FAIL_CNT_EN
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             f1_s;
  logic             f2_s;

  assign f1_s = att1_q & ~m_s;
  assign f2_s = att2_q & ~d_clk;

  // Both stages can fail on the same edge, so the increment is 0, 1 or 2.
  always_comb begin
    fail_cnt_d = {CNT_W{1'b0}};
    if (clr) begin
      fail_cnt_d = {CNT_W{1'b0}};
    end else begin
      fail_cnt_d = sat_add(fail_cnt_q, {1'b0, f1_s} + {1'b0, f2_s});
    end
  end

  // Failure counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_cnt_q <= {CNT_W{1'b0}};
    end else begin
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign fail_cnt = fail_cnt_q;
`else
  assign fail_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_seq_match_tracker.sv
// Scoreboard bench for seq_match_tracker (CNT_W = 2): directed vectors push expected outputs,
// a monitor pops and compares them after each rising edge.
module tb_seq_match_tracker;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clr = 1'b0;
  logic             a_clk = 1'b0;
  logic             ev_pulse = 1'b0;
  logic             d_clk = 1'b0;
  logic             match_o;
  logic             pending_o;
  logic             ovf_o;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] fail_cnt;

  typedef struct packed {
    logic       em;
    logic       ep;
    logic       eo;
    logic [1:0] emc;
    logic [1:0] efc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_no = 0;

  always #5 clk = ~clk;

  seq_match_tracker #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .a_clk     (a_clk),
    .ev_pulse  (ev_pulse),
    .d_clk     (d_clk),
    .match_o   (match_o),
    .pending_o (pending_o),
    .ovf_o     (ovf_o),
    .match_cnt (match_cnt),
    .fail_cnt  (fail_cnt)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL v%0d %s: got %0d, expected %0d", vec_no, name, act, req);
    end
  endtask

  // One edge of stimulus; the expected fail count assumes the failure counter is built.
  task automatic step(input logic r, input logic c, input logic a, input logic ev, input logic d,
                      input logic em, input logic ep, input logic eo,
                      input logic [1:0] emc, input logic [1:0] efc);
    exp_t e;
    @(negedge clk);
    rst = r; clr = c; a_clk = a; ev_pulse = ev; d_clk = d;
    e.em = em; e.ep = ep; e.eo = eo; e.emc = emc;
`ifdef SEQ_TRK_FAIL_CNT_EN
    e.efc = efc;
`else
    e.efc = 2'd0;
`endif
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        vec_no++;
        chk("match_o", int'(match_o), int'(e.em));
        chk("pending_o", int'(pending_o), int'(e.ep));
        chk("ovf_o", int'(ovf_o), int'(e.eo));
        chk("match_cnt", int'(match_cnt), int'(e.emc));
        chk("fail_cnt", int'(fail_cnt), int'(e.efc));
      end
    end
  end

  initial begin : stim
    //   r  c  a  e  d   m  p  o  mc fc
    // reset with every input high, then release
    step(1, 1, 1, 1, 1,  0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1,  0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    // single match
    step(0, 0, 1, 0, 0,  0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0,  0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1,  1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0,  0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0,  0, 0, 0, 0, 0);
    // latched end-point consumed by a later attempt
    step(0, 0, 0, 1, 0,  0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0,  0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0,  0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0,  0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1,  1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0,  0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0,  0, 0, 0, 0, 0);
    // overlapping attempts, second one fails at stage 2
    step(0, 0, 1, 0, 0,  0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0,  0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1,  1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0,  0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0,  0, 0, 0, 1, 1);
    step(0, 1, 0, 0, 0,  0, 0, 0, 0, 0);
    // overflow: second pulse while pending
    step(0, 0, 0, 1, 0,  0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0,  0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0,  0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0,  0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0,  0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0,  0, 0, 1, 0, 1);
    // clear wins over every simultaneous input
    step(0, 1, 1, 1, 1,  0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    // five pipelined matches saturate match_cnt
    step(0, 0, 1, 0, 0,  0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0,  0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 1,  1, 0, 0, 1, 0);
    step(0, 0, 1, 1, 1,  1, 0, 0, 2, 0);
    step(0, 0, 1, 1, 1,  1, 0, 0, 3, 0);
    step(0, 0, 0, 1, 1,  1, 0, 0, 3, 0);
    step(0, 0, 0, 0, 1,  1, 0, 0, 3, 0);
    step(0, 0, 0, 0, 0,  0, 0, 0, 3, 0);
    // simultaneous f1+f2, twice: 0 -> 2 -> clamp at 3
    step(0, 0, 1, 0, 0,  0, 0, 0, 3, 0);
    step(0, 0, 1, 1, 0,  0, 0, 0, 3, 0);
    step(0, 0, 0, 0, 0,  0, 0, 0, 3, 2);
    step(0, 0, 0, 0, 0,  0, 0, 0, 3, 2);
    step(0, 0, 1, 0, 0,  0, 0, 0, 3, 2);
    step(0, 0, 1, 1, 0,  0, 0, 0, 3, 2);
    step(0, 0, 0, 0, 0,  0, 0, 0, 3, 3);
    step(0, 0, 0, 0, 0,  0, 0, 0, 3, 3);
    step(0, 1, 0, 0, 0,  0, 0, 0, 0, 0);
    // clear kills an attempt about to match
    step(0, 0, 1, 0, 0,  0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0,  0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 1,  0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    // mid-operation reset drops in-flight attempts
    step(0, 0, 1, 0, 0,  0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0,  0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1,  0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1,  0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0,  0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
